// File: rtl/trigger_pkg.sv
// Shared types and helpers for the multi-channel coincidence trigger.
// Imported by the trigger top level and by its testbench.
package trigger_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    FIRE   = 2'd2,
    DEAD   = 2'd3
  } trig_state_t;

  localparam int NCH_DEFAULT = 4;
  localparam int MAX_NCH     = 16;
  localparam int MAJ_W       = $clog2(NCH_DEFAULT + 1);
  localparam int POP_W       = $clog2(MAX_NCH + 1);

  // Number of set bits; callers zero-extend narrower masks to MAX_NCH.
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_NCH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_NCH; i++) begin
      n = n + {{(POP_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/coincidence_trigger_if.sv
// Configuration, sample and result bundle of the coincidence trigger.
// The trigger uses the slave view; the readout controller drives the master view.
interface coincidence_trigger_if #(
  parameter int WIDTH = 12,
  parameter int NCH   = 4,
  parameter int DT_W  = 30,
  parameter int WIN_W = 8,
  parameter int CNT_W = 32,
  parameter int MAJ_W = $clog2(NCH + 1)
);

  logic [NCH*WIDTH-1:0] data_in;
  logic [NCH*WIDTH-1:0] threshold;
  logic [WIDTH-1:0]     hysteresis;
  logic [NCH-1:0]       polarity;
  logic [NCH-1:0]       ch_enable;
  logic [MAJ_W-1:0]     majority;
  logic [WIN_W-1:0]     coinc_window;
  logic [DT_W-1:0]      disable_time;

  logic                 pulse_out;
  logic                 busy;
  logic [NCH-1:0]       ch_hit;
  logic [CNT_W-1:0]     trig_count;

  modport master (
    output data_in, threshold, hysteresis, polarity, ch_enable,
           majority, coinc_window, disable_time,
    input  pulse_out, busy, ch_hit, trig_count
  );

  modport slave (
    input  data_in, threshold, hysteresis, polarity, ch_enable,
           majority, coinc_window, disable_time,
    output pulse_out, busy, ch_hit, trig_count
  );

endinterface

// File: rtl/trigger_channel_disc.sv
// Per-channel signed threshold discriminator with hysteresis re-arm and
// selectable polarity; emits a single-cycle registered hit.
module trigger_channel_disc #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] thr,
  input  logic [WIDTH-1:0] hyst,
  input  logic             pol,
  output logic             hit_q
);

  // Two guard bits so thr +/- hyst can never wrap for any operand values.
  localparam int EW = WIDTH + 2;

  logic signed [EW-1:0] d_x;
  logic signed [EW-1:0] t_x;
  logic signed [EW-1:0] h_x;
  logic signed [EW-1:0] lo;
  logic signed [EW-1:0] hi;
  logic                 hit_cond;
  logic                 rearm_cond;
  logic                 armed;

  assign d_x = {{2{data[WIDTH-1]}}, data};
  assign t_x = {{2{thr[WIDTH-1]}}, thr};
  assign h_x = {2'b00, hyst};
  assign lo  = t_x - h_x;
  assign hi  = t_x + h_x;

  assign hit_cond   = pol ? (d_x < t_x)  : (d_x > t_x);
  assign rearm_cond = pol ? (d_x >= hi) : (d_x <= lo);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      hit_q <= armed && hit_cond;
      if (armed && hit_cond) begin
        armed <= 1'b0;
      end else if (rearm_cond) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/coincidence_trigger.sv
// NCH-channel coincidence/majority trigger: per-channel discriminators feed
// a window FSM that fires a dead-time-wide pulse and latches the hit pattern.
module coincidence_trigger
  import trigger_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int NCH   = 4,
  parameter int DT_W  = 30,
  parameter int WIN_W = 8,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  coincidence_trigger_if.slave  bus
);

  localparam int MAJ_BITS = $clog2(NCH + 1);

  trig_state_t         state;
  logic [NCH-1:0]      hit_q;
  logic [NCH-1:0]      hits;
  logic [NCH-1:0]      mask;
  logic [NCH-1:0]      mask_or;
  logic [MAJ_BITS-1:0] maj_live;
  logic [MAJ_BITS-1:0] maj_q;
  logic [POP_W-1:0]    maj_live_w;
  logic [POP_W-1:0]    maj_q_w;
  logic [POP_W-1:0]    pop_hits;
  logic [POP_W-1:0]    pop_or;
  logic [WIN_W-1:0]    win_cnt;
  logic [DT_W-1:0]     dead_cnt;
  logic [NCH-1:0]      ch_hit_q;
  logic [CNT_W-1:0]    trig_cnt_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    trigger_channel_disc #(
      .WIDTH (WIDTH)
    ) u_disc (
      .clk   (clk),
      .reset (reset),
      .data  (bus.data_in[i*WIDTH +: WIDTH]),
      .thr   (bus.threshold[i*WIDTH +: WIDTH]),
      .hyst  (bus.hysteresis),
      .pol   (bus.polarity[i]),
      .hit_q (hit_q[i])
    );
  end

  assign hits    = hit_q & bus.ch_enable;
  assign mask_or = mask | hits;

  // A majority of zero would fire on nothing; treat it as one.
  assign maj_live   = (bus.majority == '0) ? MAJ_BITS'(1) : bus.majority;
  assign maj_live_w = POP_W'(maj_live);
  assign maj_q_w    = POP_W'(maj_q);
  assign pop_hits   = popcount(MAX_NCH'(hits));
  assign pop_or     = popcount(MAX_NCH'(mask_or));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mask       <= '0;
      maj_q      <= '0;
      win_cnt    <= '0;
      dead_cnt   <= '0;
      ch_hit_q   <= '0;
      trig_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hits != '0) begin
            maj_q   <= maj_live;
            win_cnt <= bus.coinc_window;
            if (pop_hits >= maj_live_w) begin
              mask  <= hits;
              state <= FIRE;
            end else if (bus.coinc_window != '0) begin
              mask  <= hits;
              state <= WINDOW;
            end else begin
              mask  <= '0;
            end
          end
        end
        WINDOW: begin
          mask <= mask_or;
          if (pop_or >= maj_q_w) begin
            state <= FIRE;
          end else begin
            win_cnt <= win_cnt - WIN_W'(1);
            if (win_cnt == WIN_W'(1)) begin
              mask  <= '0;
              state <= IDLE;
            end
          end
        end
        FIRE: begin
          ch_hit_q   <= mask;
          trig_cnt_q <= trig_cnt_q + CNT_W'(1);
          dead_cnt   <= bus.disable_time;
          mask       <= '0;
          state      <= DEAD;
        end
        DEAD: begin
          // Hits are deliberately ignored here; discriminators keep tracking.
          if (dead_cnt != '0) begin
            dead_cnt <= dead_cnt - DT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIRE plus disable_time DEAD cycles gives a pulse of disable_time+1.
  assign bus.pulse_out  = (state == FIRE) || ((state == DEAD) && (dead_cnt != '0));
  assign bus.busy       = (state != IDLE);
  assign bus.ch_hit     = ch_hit_q;
  assign bus.trig_count = trig_cnt_q;

endmodule

// File: tb/tb_coincidence_trigger.sv
// Directed bench for the coincidence trigger: single-channel fire, hysteresis,
// coincidence window edges, polarity, unreachable majority and mid-event reset.
module tb_coincidence_trigger;
  import trigger_pkg::*;

  localparam int WIDTH = 12;
  localparam int NCH   = 4;
  localparam int DT_W  = 30;
  localparam int WIN_W = 8;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset;

  int total = 0;
  int bad   = 0;
  int rises = 0;
  int highs = 0;
  logic prev_pulse = 1'b0;

  coincidence_trigger_if #(
    .WIDTH (WIDTH), .NCH (NCH), .DT_W (DT_W), .WIN_W (WIN_W), .CNT_W (CNT_W)
  ) bus ();

  coincidence_trigger #(
    .WIDTH (WIDTH), .NCH (NCH), .DT_W (DT_W), .WIN_W (WIN_W), .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor on the inactive edge: rising edges and high cycles.
  always @(negedge clk) begin
    if (bus.pulse_out && !prev_pulse) rises++;
    if (bus.pulse_out) highs++;
    prev_pulse = bus.pulse_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_ch(input int ch, input int v);
    logic [WIDTH-1:0] w;
    w = v[WIDTH-1:0];
    bus.data_in[ch*WIDTH +: WIDTH] = w;
  endtask

  task automatic set_thr(input int ch, input int v);
    logic [WIDTH-1:0] w;
    w = v[WIDTH-1:0];
    bus.threshold[ch*WIDTH +: WIDTH] = w;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NCH; i++) set_ch(i, v);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < NCH; i++) set_thr(i, 100);
    bus.hysteresis   = 12'd10;
    bus.polarity     = 4'b0000;
    bus.ch_enable    = 4'b0001;
    bus.majority     = 3'd1;
    bus.coinc_window = 8'd0;
    bus.disable_time = 30'd5;
    set_all(0);
    wait_cycles(2);
    total++; if (bus.pulse_out !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%0b want=0", bus.pulse_out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.ch_hit !== 4'b0000) begin bad++; $display("FAIL reset_ch_hit got=%b want=0000", bus.ch_hit); end
    total++; if (bus.trig_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.trig_count); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_fire();
    int r0, h0;
    set_ch(0, 0);   step();
    set_ch(0, 50);  step();
    set_ch(0, 100); step();
    r0 = rises; h0 = highs;
    set_ch(0, 150); step();
    total++; if (bus.pulse_out !== 1'b0) begin bad++; $display("FAIL single_early got=%0b want=0", bus.pulse_out); end
    step();
    total++; if (bus.pulse_out !== 1'b1) begin bad++; $display("FAIL single_latency got=%0b want=1", bus.pulse_out); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b want=1", bus.busy); end
    wait_cycles(12);
    total++; if (rises - r0 != 1) begin bad++; $display("FAIL single_pulses got=%0d want=1", rises - r0); end
    total++; if (highs - h0 != 6) begin bad++; $display("FAIL single_width got=%0d want=6", highs - h0); end
    total++; if (bus.ch_hit !== 4'b0001) begin bad++; $display("FAIL single_ch_hit got=%b want=0001", bus.ch_hit); end
    total++; if (bus.trig_count !== 32'd1) begin bad++; $display("FAIL single_count got=%0d want=1", bus.trig_count); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%0b want=0", bus.busy); end
  endtask

  task automatic test_hysteresis();
    int r0;
    r0 = rises;
    for (int i = 0; i < 8; i++) begin
      set_ch(0, (i % 2 == 0) ? 95 : 105);
      step();
    end
    wait_cycles(2);
    total++; if (rises - r0 != 0) begin bad++; $display("FAIL hyst_no_rearm got=%0d want=0", rises - r0); end
    set_ch(0, 90);  step();
    set_ch(0, 101); step();
    wait_cycles(12);
    total++; if (rises - r0 != 1) begin bad++; $display("FAIL hyst_rearm got=%0d want=1", rises - r0); end
    total++; if (bus.trig_count !== 32'd2) begin bad++; $display("FAIL hyst_count got=%0d want=2", bus.trig_count); end
  endtask

  task automatic test_window_hit();
    int r0;
    bus.ch_enable    = 4'b1111;
    bus.majority     = 3'd2;
    bus.coinc_window = 8'd3;
    bus.disable_time = 30'd2;
    set_all(0); wait_cycles(2);
    r0 = rises;
    set_ch(1, 150); step();
    set_ch(1, 0);   step();
    step();
    set_ch(2, 150); step();
    set_ch(2, 0);
    wait_cycles(10);
    total++; if (rises - r0 != 1) begin bad++; $display("FAIL win_edge_fire got=%0d want=1", rises - r0); end
    total++; if (bus.ch_hit !== 4'b0110) begin bad++; $display("FAIL win_ch_hit got=%b want=0110", bus.ch_hit); end
    total++; if (bus.trig_count !== 32'd3) begin bad++; $display("FAIL win_count got=%0d want=3", bus.trig_count); end
  endtask

  task automatic test_window_miss();
    int r0;
    r0 = rises;
    set_ch(1, 150); step();
    set_ch(1, 0);   step();
    step();
    step();
    set_ch(2, 150); step();
    set_ch(2, 0);
    wait_cycles(12);
    total++; if (rises - r0 != 0) begin bad++; $display("FAIL win_late_fire got=%0d want=0", rises - r0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL win_late_idle got=%0b want=0", bus.busy); end
    total++; if (bus.trig_count !== 32'd3) begin bad++; $display("FAIL win_late_count got=%0d want=3", bus.trig_count); end
  endtask

  task automatic test_polarity();
    int r0, h0;
    bus.ch_enable    = 4'b1000;
    bus.polarity     = 4'b1000;
    set_thr(3, -200);
    bus.majority     = 3'd1;
    bus.coinc_window = 8'd0;
    bus.disable_time = 30'd1;
    set_all(0); step();
    r0 = rises; h0 = highs;
    set_ch(3, -250); step();
    set_ch(3, 0);
    wait_cycles(8);
    total++; if (rises - r0 != 1) begin bad++; $display("FAIL pol_neg_fire got=%0d want=1", rises - r0); end
    total++; if (highs - h0 != 2) begin bad++; $display("FAIL pol_width got=%0d want=2", highs - h0); end
    total++; if (bus.ch_hit !== 4'b1000) begin bad++; $display("FAIL pol_ch_hit got=%b want=1000", bus.ch_hit); end
    r0 = rises;
    set_ch(3, 300); step();
    set_ch(3, 0);
    wait_cycles(6);
    total++; if (rises - r0 != 0) begin bad++; $display("FAIL pol_pos_ignored got=%0d want=0", rises - r0); end
    total++; if (bus.trig_count !== 32'd4) begin bad++; $display("FAIL pol_count got=%0d want=4", bus.trig_count); end
  endtask

  task automatic test_majority_unreachable();
    int r0;
    bus.polarity     = 4'b0000;
    set_thr(3, 100);
    bus.ch_enable    = 4'b0011;
    bus.majority     = 3'd3;
    bus.coinc_window = 8'd3;
    bus.disable_time = 30'd5;
    set_all(0); step();
    r0 = rises;
    set_all(150); step();
    wait_cycles(10);
    total++; if (rises - r0 != 0) begin bad++; $display("FAIL maj_unreach_fire got=%0d want=0", rises - r0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL maj_unreach_idle got=%0b want=0", bus.busy); end
  endtask

  task automatic test_same_cycle_and_reset();
    bus.ch_enable    = 4'b1111;
    bus.majority     = 3'd3;
    bus.coinc_window = 8'd0;
    bus.disable_time = 30'd20;
    set_all(0);   step();
    set_all(150); step();
    step();
    total++; if (bus.pulse_out !== 1'b1) begin bad++; $display("FAIL same_cycle_fire got=%0b want=1", bus.pulse_out); end
    wait_cycles(5);
    total++; if (bus.ch_hit !== 4'b1111) begin bad++; $display("FAIL same_cycle_ch_hit got=%b want=1111", bus.ch_hit); end
    total++; if (bus.trig_count !== 32'd5) begin bad++; $display("FAIL same_cycle_count got=%0d want=5", bus.trig_count); end
    #3;
    reset = 1'b0;
    #1;
    total++; if (bus.pulse_out !== 1'b0) begin bad++; $display("FAIL abort_pulse got=%0b want=0", bus.pulse_out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", bus.busy); end
    total++; if (bus.trig_count !== 32'd0) begin bad++; $display("FAIL abort_count got=%0d want=0", bus.trig_count); end
    total++; if (bus.ch_hit !== 4'b0000) begin bad++; $display("FAIL abort_ch_hit got=%b want=0000", bus.ch_hit); end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_rearm_after_reset();
    int r0;
    bus.majority     = 3'd1;
    bus.disable_time = 30'd3;
    r0 = rises;
    wait_cycles(10);
    total++; if (rises - r0 != 0) begin bad++; $display("FAIL rearm_needed got=%0d want=0", rises - r0); end
    set_all(0);     step();
    set_ch(0, 150); step();
    wait_cycles(10);
    total++; if (rises - r0 != 1) begin bad++; $display("FAIL rearm_fire got=%0d want=1", rises - r0); end
    total++; if (bus.trig_count !== 32'd1) begin bad++; $display("FAIL rearm_count got=%0d want=1", bus.trig_count); end
    total++; if (bus.ch_hit !== 4'b0001) begin bad++; $display("FAIL rearm_ch_hit got=%b want=0001", bus.ch_hit); end
  endtask

  initial begin
    test_reset();
    test_single_fire();
    test_hysteresis();
    test_window_hit();
    test_window_miss();
    test_polarity();
    test_majority_unreachable();
    test_same_cycle_and_reset();
    test_rearm_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
